// File: rtl/arc4_engine.sv
// arc4_engine: ARC4 (RC4-drop[N]) decryptor with a single control FSM.
// Runs S-box init, key schedule, optional keystream discard and the
// length-prefixed message decrypt against external single-port memories.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   en / rdy            start request (taken only when rdy=1) / idle flag
//   key                 8*KEY_BYTES key, byte 0 in the MSBs, latched on start
//   s_addr/s_rddata/s_wrdata/s_wren   256x8 S memory, 1-cycle read latency
//   ct_addr/ct_rddata   ciphertext ROM, 1-cycle read latency; ct[0] = length
//   pt_addr/pt_wrdata/pt_wren         plaintext RAM; pt[0] receives length
module arc4_engine #(
   parameter int KEY_BYTES = 3,
   parameter int DROP_N    = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   output logic                   rdy,
   input  logic [8*KEY_BYTES-1:0] key,
   output logic [7:0]             s_addr,
   input  logic [7:0]             s_rddata,
   output logic [7:0]             s_wrdata,
   output logic                   s_wren,
   output logic [7:0]             ct_addr,
   input  logic [7:0]             ct_rddata,
   output logic [7:0]             pt_addr,
   output logic [7:0]             pt_wrdata,
   output logic                   pt_wren
);

   localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [10:0] DROP_LAST = 11'((DROP_N > 0) ? DROP_N - 1 : 0);

   typedef enum logic [4:0] {
      S_IDLE, S_INIT,
      S_K0, S_K1, S_K2, S_K3,
      S_D0, S_D1, S_D2, S_D3,
      S_L0, S_L1,
      S_P0, S_P1, S_P2, S_P3, S_P4, S_P5
   } state_t;

   state_t                 state_q, state_d;
   logic [8*KEY_BYTES-1:0] key_q, key_d;
   logic [7:0]             i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
   logic [7:0]             si_q, si_d, sj_q, sj_d;
   logic [KW-1:0]          kidx_q, kidx_d;
   logic [10:0]            drop_q, drop_d;
   logic [7:0]             j_nxt;

   // Key bytes in schedule order; the table is padded to a power of two so
   // the byte index never runs past the array.
   logic [7:0] key_bytes [2**KW];
   for (genvar b = 0; b < 2**KW; b++) begin : g_kb
      if (b < KEY_BYTES) begin : g_used
         assign key_bytes[b] = key_q[8*(KEY_BYTES-b)-1 -: 8];
      end else begin : g_pad
         assign key_bytes[b] = 8'h00;
      end
   end

   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      len_d     = len_q;
      si_d      = si_q;
      sj_d      = sj_q;
      kidx_d    = kidx_q;
      drop_d    = drop_q;
      j_nxt     = 8'h00;
      rdy       = 1'b0;
      s_addr    = 8'h00;
      s_wrdata  = 8'h00;
      s_wren    = 1'b0;
      ct_addr   = 8'h00;
      pt_addr   = 8'h00;
      pt_wrdata = 8'h00;
      pt_wren   = 1'b0;
      case (state_q)
         S_IDLE: begin
            rdy = 1'b1;
            if (en) begin
               key_d   = key;
               i_d     = 8'h00;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            s_addr   = i_q;
            s_wrdata = i_q;
            s_wren   = 1'b1;
            i_d      = i_q + 8'd1;      // wraps to 0 for the key schedule
            if (i_q == 8'hFF) begin
               j_d     = 8'h00;
               kidx_d  = '0;
               state_d = S_K0;
            end
         end
         S_K0: begin
            s_addr  = i_q;
            state_d = S_K1;
         end
         S_K1: begin
            si_d    = s_rddata;
            j_nxt   = j_q + s_rddata + key_bytes[kidx_q];
            j_d     = j_nxt;
            s_addr  = j_nxt;
            kidx_d  = (kidx_q == KW'(KEY_BYTES-1)) ? '0 : kidx_q + KW'(1);
            state_d = S_K2;
         end
         S_K2, S_D2, S_P2: begin
            sj_d     = s_rddata;
            s_addr   = i_q;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
            state_d  = (state_q == S_K2) ? S_K3 : (state_q == S_D2) ? S_D3 : S_P3;
         end
         S_K3: begin
            s_addr   = j_q;
            s_wrdata = si_q;
            s_wren   = 1'b1;
            i_d      = i_q + 8'd1;
            state_d  = S_K0;
            if (i_q == 8'hFF) begin
               // i has wrapped to 0; set up the generator
               j_d     = 8'h00;
               k_d     = 8'd1;
               drop_d  = 11'd0;
               state_d = (DROP_N > 0) ? S_D0 : S_L0;
            end
         end
         S_D0, S_P0: begin
            i_d     = i_q + 8'd1;
            s_addr  = i_q + 8'd1;
            state_d = (state_q == S_D0) ? S_D1 : S_P1;
         end
         S_D1, S_P1: begin
            si_d    = s_rddata;
            j_nxt   = j_q + s_rddata;
            j_d     = j_nxt;
            s_addr  = j_nxt;
            state_d = (state_q == S_D1) ? S_D2 : S_P2;
         end
         S_D3: begin
            s_addr   = j_q;
            s_wrdata = si_q;
            s_wren   = 1'b1;
            drop_d   = drop_q + 11'd1;
            state_d  = (drop_q == DROP_LAST) ? S_L0 : S_D0;
         end
         S_L0: begin
            ct_addr = 8'h00;
            state_d = S_L1;
         end
         S_L1: begin
            len_d     = ct_rddata;
            pt_addr   = 8'h00;
            pt_wrdata = ct_rddata;
            pt_wren   = 1'b1;
            k_d       = 8'd1;
            state_d   = (ct_rddata == 8'h00) ? S_IDLE : S_P0;
         end
         S_P3: begin
            s_addr   = j_q;
            s_wrdata = si_q;
            s_wren   = 1'b1;
            state_d  = S_P4;
         end
         S_P4: begin
            // sum of the swapped pair is the same as before the swap
            s_addr  = si_q + sj_q;
            ct_addr = k_q;
            state_d = S_P5;
         end
         S_P5: begin
            pt_addr   = k_q;
            pt_wrdata = s_rddata ^ ct_rddata;
            pt_wren   = 1'b1;
            if (k_q == len_q) begin
               state_d = S_IDLE;       // k stops at L, so L=255 never wraps
            end else begin
               k_d     = k_q + 8'd1;
               state_d = S_P0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         key_q   <= '0;
         i_q     <= 8'h00;
         j_q     <= 8'h00;
         k_q     <= 8'h00;
         len_q   <= 8'h00;
         si_q    <= 8'h00;
         sj_q    <= 8'h00;
         kidx_q  <= '0;
         drop_q  <= 11'd0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         len_q   <= len_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         kidx_q  <= kidx_d;
         drop_q  <= drop_d;
      end
   end

endmodule
